// File: rtl/line_fifo_dp.sv
// Single-clock FWFT FIFO on an inferred dual-port RAM with a 2-entry prefetch output stage.
// Define LINE_FIFO_WATERMARK_EN to add the highWater peak-fill output.
module line_fifo_dp #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 9,
    parameter int ALMOST_FULL_LEVEL  = 480,
    parameter int ALMOST_EMPTY_LEVEL = 16
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  clear,
    input  logic                  pushValid,
    output logic                  pushReady,
    input  logic [DATA_WIDTH-1:0] pushData,
    output logic                  popValid,
    input  logic                  popReady,
    output logic [DATA_WIDTH-1:0] popData,
    output logic [ADDR_WIDTH:0]   fillLevel,
    output logic                  almostFull,
    output logic                  almostEmpty
`ifdef LINE_FIFO_WATERMARK_EN
   ,output logic [ADDR_WIDTH:0]   highWater
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LVL_W = ADDR_WIDTH + 1;

    if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL >= DEPTH) begin : g_param_err
        $error("line_fifo_dp: threshold levels out of range for DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_vld;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_buf_cnt;
    logic [LVL_W-1:0]      r_fill;
    logic                  r_push_ready;
    logic                  r_almost_full;
    logic                  r_almost_empty;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_en;
    logic [LVL_W-1:0]      w_fill_nxt;
    logic [LVL_W-1:0]      w_ram_cnt;
    logic [2:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;
    logic [1:0]            w_buf_cnt_nxt;

    assign w_push     = pushValid && r_push_ready;
    assign w_pop      = popReady && (r_buf_cnt != 2'd0);
    assign w_fill_nxt = r_fill + LVL_W'(w_push) - LVL_W'(w_pop);

    // Words still sitting in the RAM: everything counted minus the prefetch stage and the read in flight.
    assign w_ram_cnt = r_fill - LVL_W'(r_buf_cnt) - LVL_W'(r_rd_vld);
    assign w_occ     = 3'(r_buf_cnt) + 3'(r_rd_vld) - 3'(w_pop);
    assign w_rd_en   = !clear && (w_ram_cnt != '0) && (w_occ < 3'd2);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_buf0_nxt    = r_buf0;
        w_buf1_nxt    = r_buf1;
        w_buf_cnt_nxt = r_buf_cnt;
        if (w_pop) begin
            w_buf0_nxt    = r_buf1;
            w_buf_cnt_nxt = w_buf_cnt_nxt - 2'd1;
        end
        if (r_rd_vld) begin
            if (w_buf_cnt_nxt == 2'd0) begin
                w_buf0_nxt = r_rd_data;
            end else begin
                w_buf1_nxt = r_rd_data;
            end
            w_buf_cnt_nxt = w_buf_cnt_nxt + 2'd1;
        end
    end

    // NOTE: the RAM and its read register have no reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= pushData;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rd_vld       <= 1'b0;
            r_buf0         <= '0;
            r_buf1         <= '0;
            r_buf_cnt      <= 2'd0;
            r_fill         <= '0;
            r_push_ready   <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else if (clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rd_vld       <= 1'b0;
            r_buf0         <= '0;
            r_buf1         <= '0;
            r_buf_cnt      <= 2'd0;
            r_fill         <= '0;
            r_push_ready   <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_vld       <= w_rd_en;
            r_buf0         <= w_buf0_nxt;
            r_buf1         <= w_buf1_nxt;
            r_buf_cnt      <= w_buf_cnt_nxt;
            r_fill         <= w_fill_nxt;
            // A pop this cycle frees the slot only for the following cycle.
            r_push_ready   <= (w_fill_nxt < LVL_W'(DEPTH));
            r_almost_full  <= (w_fill_nxt >= LVL_W'(ALMOST_FULL_LEVEL));
            r_almost_empty <= (w_fill_nxt <= LVL_W'(ALMOST_EMPTY_LEVEL));
        end
    end

`ifdef LINE_FIFO_WATERMARK_EN
    logic [LVL_W-1:0] r_high_water;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_high_water <= '0;
        end else if (clear) begin
            r_high_water <= '0;
        end else if (w_fill_nxt > r_high_water) begin
            r_high_water <= w_fill_nxt;
        end
    end

    assign highWater = r_high_water;
`endif

    assign pushReady   = r_push_ready;
    assign popValid    = (r_buf_cnt != 2'd0);
    assign popData     = r_buf0;
    assign fillLevel   = r_fill;
    assign almostFull  = r_almost_full;
    assign almostEmpty = r_almost_empty;

endmodule
